// File: rtl/treelut_enc_pkg.sv
// Shared types and constants for the TreeLUT feature encoder: defaults, threshold encoding, FSM states.
package treelut_enc_pkg;

  localparam int DEF_FEAT_W       = 8;
  localparam int DEF_MAX_THR      = 6;
  localparam int DEF_NUM_FEATURES = 31;

  localparam int THR_W = DEF_FEAT_W + 1;
  // One above the largest feature value, so (feature >= THR_DISABLED) can never hold.
  localparam logic [THR_W-1:0] THR_DISABLED = THR_W'(1 << DEF_FEAT_W);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    OUT     = 2'd2
  } enc_state_e;

  function automatic int slot_addr(input int feature, input int slot,
                                   input int max_thr = DEF_MAX_THR);
    return feature * max_thr + slot;
  endfunction

endpackage

// File: rtl/treelut_thr_cmp.sv
// One feature against MAX_THR thresholds; purely combinational, no backpressure.
module treelut_thr_cmp
  import treelut_enc_pkg::*;
#(
  parameter int FEAT_W  = DEF_FEAT_W,
  parameter int MAX_THR = DEF_MAX_THR
) (
  input  logic [FEAT_W-1:0]             feat,
  input  logic [MAX_THR*(FEAT_W+1)-1:0] thr,
  output logic [MAX_THR-1:0]            hit
);

  localparam int TW = FEAT_W + 1;

  // The zero-extended feature lets the all-ones-plus-one code act as "never".
  always_comb begin
    hit = '0;
    for (int s = 0; s < MAX_THR; s++) begin
      hit[s] = ({1'b0, feat} >= thr[s*TW +: TW]);
    end
  end

endmodule

// File: rtl/treelut_feat_encoder.sv
// Streams quantized features into a packed threshold-bit vector; vector valid 1 cycle after the last feature.
// s_ready drops while a finished vector waits for m_ready; FEAT_ENC_PINGPONG_EN adds an output buffer so collection continues.
module treelut_feat_encoder
  import treelut_enc_pkg::*;
#(
  parameter  int NUM_FEATURES = DEF_NUM_FEATURES,
  parameter  int FEAT_W       = DEF_FEAT_W,
  parameter  int MAX_THR      = DEF_MAX_THR,
  localparam int VEC_W        = NUM_FEATURES * MAX_THR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [7:0]        cfg_addr,
  input  logic [FEAT_W:0]   cfg_data,
  output logic              cfg_drop,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [FEAT_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [VEC_W-1:0]  m_vec,
  output logic              frame_err
);

  localparam int THR_BITS = FEAT_W + 1;
  localparam int IDX_W    = $clog2(NUM_FEATURES);
  localparam int ADDR_W   = $clog2(VEC_W);
  localparam logic [THR_BITS-1:0] THR_OFF = THR_BITS'(1 << FEAT_W);

  enc_state_e          state_q, state_d;
  logic [IDX_W-1:0]    feat_idx_q, feat_idx_d;
  logic [VEC_W-1:0]    m_vec_q, m_vec_d;
  logic                m_valid_q, m_valid_d;
  logic                frame_err_q, frame_err_d;
  logic                cfg_drop_q, cfg_drop_d;
  logic [THR_BITS-1:0] thr_q [VEC_W];

  logic [MAX_THR*THR_BITS-1:0] thr_sel;
  logic [MAX_THR-1:0]          cmp_bits;
  logic                        cfg_ok;
  logic                        last_slot;
  logic                        frame_end;

`ifdef FEAT_ENC_PINGPONG_EN
  logic [VEC_W-1:0] asm_q, asm_d;
`endif

  always_comb begin
    thr_sel = '0;
    for (int s = 0; s < MAX_THR; s++) begin
      thr_sel[s*THR_BITS +: THR_BITS] =
        thr_q[ADDR_W'(slot_addr(int'(feat_idx_q), s, MAX_THR))];
    end
  end

  treelut_thr_cmp #(
    .FEAT_W (FEAT_W),
    .MAX_THR(MAX_THR)
  ) u_thr_cmp (
    .feat(s_data),
    .thr (thr_sel),
    .hit (cmp_bits)
  );

  // Thresholds may only change between frames so a frame never sees a mix of old and new values.
  always_comb begin
    cfg_ok = cfg_we && (state_q == COLLECT) && (feat_idx_q == '0)
             && ({24'd0, cfg_addr} < 32'(VEC_W));
`ifdef FEAT_ENC_PINGPONG_EN
    cfg_ok = cfg_ok && !m_valid_q;
`endif
    cfg_drop_d = cfg_drop_q | (cfg_we & ~cfg_ok);
  end

  assign last_slot = (feat_idx_q == IDX_W'(NUM_FEATURES - 1));
  assign frame_end = s_last | last_slot;

  always_comb begin
    state_d     = state_q;
    feat_idx_d  = feat_idx_q;
    m_vec_d     = m_vec_q;
    m_valid_d   = m_valid_q;
    frame_err_d = frame_err_q;
    s_ready     = 1'b0;
`ifdef FEAT_ENC_PINGPONG_EN
    asm_d = asm_q;
    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
      m_vec_d   = '0;
    end
`endif
    case (state_q)
      IDLE: state_d = COLLECT;
      COLLECT: begin
        s_ready = 1'b1;
        if (s_valid) begin
          feat_idx_d = feat_idx_q + IDX_W'(1);
`ifdef FEAT_ENC_PINGPONG_EN
          asm_d[feat_idx_q*MAX_THR +: MAX_THR] = cmp_bits;
`else
          m_vec_d[feat_idx_q*MAX_THR +: MAX_THR] = cmp_bits;
`endif
          if (frame_end) begin
            feat_idx_d = '0;
            // Unwritten slices stay zero because the assembly register is cleared per frame.
            if (s_last != last_slot) frame_err_d = 1'b1;
`ifdef FEAT_ENC_PINGPONG_EN
            if (!m_valid_q || m_ready) begin
              m_vec_d   = asm_d;
              m_valid_d = 1'b1;
              asm_d     = '0;
            end else begin
              state_d = OUT;
            end
`else
            m_valid_d = 1'b1;
            state_d   = OUT;
`endif
          end
        end
      end
      OUT: begin
        if (m_ready) begin
          state_d = COLLECT;
`ifdef FEAT_ENC_PINGPONG_EN
          m_vec_d   = asm_q;
          m_valid_d = 1'b1;
          asm_d     = '0;
`else
          m_vec_d   = '0;
          m_valid_d = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      feat_idx_q  <= '0;
      m_vec_q     <= '0;
      m_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      cfg_drop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      feat_idx_q  <= feat_idx_d;
      m_vec_q     <= m_vec_d;
      m_valid_q   <= m_valid_d;
      frame_err_q <= frame_err_d;
      cfg_drop_q  <= cfg_drop_d;
    end
  end

`ifdef FEAT_ENC_PINGPONG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) asm_q <= '0;
    else        asm_q <= asm_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < VEC_W; i++) thr_q[i] <= THR_OFF;
    end else if (cfg_ok) begin
      thr_q[ADDR_W'(cfg_addr)] <= cfg_data;
    end
  end

  assign m_vec     = m_vec_q;
  assign m_valid   = m_valid_q;
  assign frame_err = frame_err_q;
  assign cfg_drop  = cfg_drop_q;

endmodule

// File: tb/tb_treelut_feat_encoder.sv
// Directed bench for treelut_feat_encoder; honours FEAT_ENC_PINGPONG_EN for period and s_ready expectations.
module tb_treelut_feat_encoder;
  import treelut_enc_pkg::*;

  localparam int NF = 31;
  localparam int FW = 8;
  localparam int MT = 6;
  localparam int VW = NF * MT;
`ifdef FEAT_ENC_PINGPONG_EN
  localparam int EXP_PERIOD = 31;
  localparam logic HOLD_READY = 1'b1;
`else
  localparam int EXP_PERIOD = 32;
  localparam logic HOLD_READY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cfg_we = 1'b0;
  logic [7:0]    cfg_addr = '0;
  logic [FW:0]   cfg_data = '0;
  logic          cfg_drop;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [FW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [VW-1:0] m_vec;
  logic          frame_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic mv_before_last;

  logic [FW-1:0] feat_vals [NF];
  logic [FW:0]   thr_m [VW];
  int            hs_cyc [$];
  logic [VW-1:0] hs_vec [$];

  typedef struct {
    logic [FW:0]   thr;
    logic [FW-1:0] data;
    logic          exp;
  } bnd_t;
  bnd_t bnd [6];

  treelut_feat_encoder #(
    .NUM_FEATURES(NF),
    .FEAT_W      (FW),
    .MAX_THR     (MT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .cfg_drop (cfg_drop),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_vec    (m_vec),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      hs_cyc.push_back(cyc);
      hs_vec.push_back(m_vec);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic write_cfg(input logic [7:0] addr, input logic [FW:0] data, input bit apply);
    cfg_we   = 1'b1;
    cfg_addr = addr;
    cfg_data = data;
    tick();
    cfg_we = 1'b0;
    if (apply) thr_m[addr] = data;
  endtask

  task automatic send_frame(input int first, input int n, input int last_at, input bit cfg_first);
    int budget;
    for (int i = first; i < first + n; i++) begin
      s_valid = 1'b1;
      s_data  = feat_vals[i];
      s_last  = (i == last_at);
      budget  = 0;
      while (!s_ready && budget < 100) begin
        tick();
        budget++;
      end
      if (budget >= 100) begin
        chk("s_ready_timeout", VW'(s_ready), VW'(1));
        break;
      end
      if (i == first + n - 1) mv_before_last = m_valid;
      tick();
      if (cfg_first && i == first) cfg_we = 1'b0;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  function automatic logic [VW-1:0] model_vec(input int n);
    logic [VW-1:0] v;
    v = '0;
    for (int f = 0; f < n; f++)
      for (int s = 0; s < MT; s++)
        v[f*MT+s] = ({1'b0, feat_vals[f]} >= thr_m[f*MT+s]);
    return v;
  endfunction

  initial begin
    logic [VW-1:0] exp_a, exp_v, hold_v;
    bnd[0] = '{thr: 9'd0,   data: 8'd0,   exp: 1'b1};
    bnd[1] = '{thr: 9'd255, data: 8'd255, exp: 1'b1};
    bnd[2] = '{thr: 9'd256, data: 8'd255, exp: 1'b0};
    bnd[3] = '{thr: 9'd100, data: 8'd99,  exp: 1'b0};
    bnd[4] = '{thr: 9'd100, data: 8'd100, exp: 1'b1};
    bnd[5] = '{thr: 9'd1,   data: 8'd0,   exp: 1'b0};
    for (int i = 0; i < VW; i++) thr_m[i] = THR_DISABLED;
    exp_a = '1;
    exp_a[1] = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_s_ready", VW'(s_ready), VW'(0));
    chk("rst_m_valid", VW'(m_valid), VW'(0));
    chk("rst_m_vec", m_vec, '0);
    chk("rst_cfg_drop", VW'(cfg_drop), VW'(0));
    chk("rst_frame_err", VW'(frame_err), VW'(0));
    tick();
    tick();
    rst_n = 1'b1;
    chk("idle_s_ready", VW'(s_ready), VW'(0));
    tick();
    chk("collect_s_ready", VW'(s_ready), VW'(1));

    for (int a = 0; a < VW; a++)
      write_cfg(8'(a), (a == 0) ? 9'd10 : (a == 1) ? 9'd200 : 9'd0, 1'b1);
    chk("cfg_drop_clean", VW'(cfg_drop), VW'(0));

    // Frame A: nominal, consumer always ready.
    for (int i = 0; i < NF; i++) feat_vals[i] = 8'd100;
    m_ready = 1'b1;
    send_frame(0, NF, NF - 1, 1'b0);
    chk("a_valid_before_last", VW'(mv_before_last), VW'(0));
    chk("a_m_valid", VW'(m_valid), VW'(1));
    chk("a_m_vec", m_vec, exp_a);
    chk("a_frame_err", VW'(frame_err), VW'(0));
    tick();
    chk("a_drained_valid", VW'(m_valid), VW'(0));
    chk("a_drained_vec", m_vec, '0);
    chk("a_drained_ready", VW'(s_ready), VW'(1));

    // Frame B: output stalled for 5 cycles.
    m_ready = 1'b0;
    send_frame(0, NF, NF - 1, 1'b0);
    hold_v = m_vec;
    chk("b_m_vec", m_vec, exp_a);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("b_hold_vec%0d", c), m_vec, hold_v);
      chk($sformatf("b_hold_valid%0d", c), VW'(m_valid), VW'(1));
      chk($sformatf("b_hold_ready%0d", c), VW'(s_ready), VW'(HOLD_READY));
    end
    m_ready = 1'b1;
    tick();
    chk("b_release_valid", VW'(m_valid), VW'(0));
    chk("b_release_ready", VW'(s_ready), VW'(1));

    // Early s_last on the 4th feature, then a clean frame.
    send_frame(0, 4, 3, 1'b0);
    chk("early_valid", VW'(m_valid), VW'(1));
    chk("early_frame_err", VW'(frame_err), VW'(1));
    chk("early_upper_zero", m_vec >> 24, '0);
    chk("early_lower", VW'(m_vec[23:0]), VW'(24'hFFFFFD));
    tick();
    send_frame(0, NF, NF - 1, 1'b0);
    chk("after_early_vec", m_vec, exp_a);
    tick();

    // Config write mid-frame must be dropped.
    send_frame(0, 3, -1, 1'b0);
    write_cfg(8'd0, 9'd250, 1'b0);
    chk("midframe_cfg_drop", VW'(cfg_drop), VW'(1));
    send_frame(3, NF - 3, NF - 1, 1'b0);
    chk("midframe_thr_unchanged", m_vec, exp_a);
    tick();

    // Boundary table: slot 0 of features 0..5.
    for (int k = 0; k < 6; k++) begin
      write_cfg(8'(k * MT), bnd[k].thr, 1'b1);
      feat_vals[k] = bnd[k].data;
    end
    send_frame(0, NF, NF - 1, 1'b0);
    for (int k = 0; k < 6; k++)
      chk($sformatf("bnd%0d", k), VW'(m_vec[k*MT]), VW'(bnd[k].exp));
    chk("bnd_full", m_vec, model_vec(NF));
    tick();

    // Config write together with the first feature: that feature sees the old threshold.
    for (int i = 0; i < NF; i++) feat_vals[i] = 8'd100;
    exp_v = model_vec(NF);
    cfg_addr = 8'd0;
    cfg_data = 9'd256;
    cfg_we   = 1'b1;
    send_frame(0, NF, NF - 1, 1'b1);
    thr_m[0] = 9'd256;
    chk("same_cycle_old_thr", m_vec, exp_v);
    tick();

    // Back-to-back frames with m_ready high.
    for (int i = 0; i < NF; i++) feat_vals[i] = 8'(i * 8);
    exp_v = model_vec(NF);
    hs_cyc.delete();
    hs_vec.delete();
    for (int f = 0; f < 3; f++) send_frame(0, NF, NF - 1, 1'b0);
    tick();
    tick();
    chk("b2b_frames", VW'(hs_cyc.size()), VW'(3));
    if (hs_cyc.size() == 3) begin
      chk("b2b_period1", VW'(hs_cyc[1] - hs_cyc[0]), VW'(EXP_PERIOD));
      chk("b2b_period2", VW'(hs_cyc[2] - hs_cyc[1]), VW'(EXP_PERIOD));
      for (int f = 0; f < 3; f++) chk($sformatf("b2b_vec%0d", f), hs_vec[f], exp_v);
    end

    // Reset mid-frame discards everything; thresholds return to disabled.
    send_frame(0, 10, -1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", VW'(m_valid), VW'(0));
    chk("midrst_cfg_drop", VW'(cfg_drop), VW'(0));
    chk("midrst_frame_err", VW'(frame_err), VW'(0));
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < VW; i++) thr_m[i] = THR_DISABLED;
    write_cfg(8'd186, 9'd0, 1'b0);
    chk("oob_cfg_drop", VW'(cfg_drop), VW'(1));
    for (int i = 0; i < NF; i++) feat_vals[i] = 8'd255;
    send_frame(0, NF, NF - 1, 1'b0);
    chk("postrst_valid", VW'(m_valid), VW'(1));
    chk("postrst_disabled_vec", m_vec, '0);
    chk("postrst_frame_err", VW'(frame_err), VW'(0));
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
